vram_arbiter: RTL



---
 rtl/vram_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scan-out fetch has priority, the host fills free cycles,
// and a starvation guard forces a host grant (dropping one video fetch) after a bounded wait.
module vram_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_miss,
    output logic [15:0]   vid_miss_cnt,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          starve_active
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic vid;
        logic miss;
        logic hrd;
    } tag_t;

    logic [CW-1:0] wcnt;
    logic          force_gnt, host_gnt, vid_gnt, drop;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    tag_t          tag_s1;

    always_comb begin
        force_gnt     = host_valid && (wcnt == CW'(STARVE_LIMIT));
        host_gnt      = !reset && (force_gnt || (host_valid && !vid_req));
        vid_gnt       = !reset && vid_req && !host_gnt;
        drop          = !reset && force_gnt && vid_req;
        host_ready    = host_gnt;
        starve_active = !reset && force_gnt;
        ram_we        = host_gnt && host_we;
        // Idle cycles replay the last address/data so the RAM bus does not toggle
        ram_addr      = addr_q;
        ram_wdata     = wdata_q;
        if (host_gnt) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end else if (vid_gnt) begin
            ram_addr  = vid_addr;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wcnt    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_s1  <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
            if (!host_valid || host_gnt)
                wcnt <= '0;
            else if (wcnt != CW'(STARVE_LIMIT))
                wcnt <= wcnt + CW'(1);
            // A dropped fetch still occupies a return slot so scan-out sees fixed latency
            tag_s1.vid  <= vid_gnt || drop;
            tag_s1.miss <= drop;
            tag_s1.hrd  <= host_gnt && !host_we;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_rvalid   <= 1'b0;
            vid_miss     <= 1'b0;
            vid_rdata    <= '0;
            vid_miss_cnt <= '0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
        end else begin
            vid_rvalid  <= tag_s1.vid;
            vid_miss    <= tag_s1.miss;
            host_rvalid <= tag_s1.hrd;
            if (tag_s1.vid && !tag_s1.miss)
                vid_rdata <= ram_rdata;
            if (tag_s1.miss && vid_miss_cnt != 16'hFFFF)
                vid_miss_cnt <= vid_miss_cnt + 16'd1;
            if (tag_s1.hrd)
                host_rdata <= ram_rdata;
        end
    end
endmodule
